// File: rtl/servant_irq_stim.sv
`default_nettype none
// ============================================================================
// Module      : servant_irq_stim
// Description : Multi-channel external-interrupt stimulus/checker for SERV
//               benches: programmable timers raise ext_irq, new_irq/mret
//               pulses are tracked for acknowledge, latency and protocol.
// Revision    : 1.0 - initial release
// ============================================================================
module servant_irq_stim #(
    parameter int                        CHANNELS   = 2,
    parameter int                        CW         = 32,
    parameter logic [CHANNELS*CW-1:0]    FIRST_TIME = {CHANNELS{32'd3000}},
    parameter logic [CHANNELS*CW-1:0]    PERIOD     = {CHANNELS{32'd5000}},
    parameter logic [CHANNELS-1:0]       PERIODIC   = {CHANNELS{1'b0}},
    parameter int                        TIMEOUT    = 1000
) (
    input  logic                wb_clk,
    input  logic                wb_rst_n,
    input  logic                i_en,
    input  logic                i_new_irq,
    input  logic                i_mret,
    output logic                o_ext_irq,
    output logic [CHANNELS-1:0] o_pending,
    output logic [2:0]          o_sel,
    output logic [15:0]         o_irq_count,
    output logic [CW-1:0]       o_max_lat,
    output logic                o_overrun,
    output logic                o_err
);

    localparam logic [CW-1:0] c_timeout = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SERV = 2'd2
    } state_t;

    state_t                r_state;
    logic [CHANNELS-1:0]   r_pending;
    logic [2:0]            r_sel;
    logic [CW-1:0]         r_lat;
    logic [15:0]           r_irq_count;
    logic [CW-1:0]         r_max_lat;
    logic                  r_overrun;
    logic                  r_err;

    logic [CHANNELS-1:0]   w_fire;
    logic [CHANNELS-1:0]   w_clear;
    logic [2:0]            w_low_idx;
    logic                  w_proto_err;

    // A timer fires on the enabled edge that samples zero, then reloads or retires.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [CW-1:0] r_cnt;
        logic          r_done;

        assign w_fire[gi] = i_en && !r_done && (r_cnt == '0);

        always_ff @(posedge wb_clk or negedge wb_rst_n) begin
            if (!wb_rst_n) begin
                r_cnt  <= FIRST_TIME[gi*CW +: CW];
                r_done <= 1'b0;
            end else if (i_en && !r_done) begin
                if (r_cnt == '0) begin
                    if (PERIODIC[gi])
                        r_cnt <= PERIOD[gi*CW +: CW];
                    else
                        r_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_low_idx = 3'd0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (r_pending[i])
                w_low_idx = 3'(i);
        end
    end

    always_comb begin
        w_clear = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (r_state == ST_SERV && i_mret && r_sel == 3'(i))
                w_clear[i] = 1'b1;
        end
    end

    assign w_proto_err = (i_new_irq && r_state != ST_WAIT)
                      || (i_mret && r_state != ST_SERV)
                      || (r_state == ST_WAIT && r_lat == c_timeout);

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state     <= ST_IDLE;
            r_pending   <= '0;
            r_sel       <= 3'd0;
            r_lat       <= '0;
            r_irq_count <= 16'd0;
            r_max_lat   <= '0;
            r_overrun   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            // A fire on the edge that retires the same channel is a fresh request.
            r_pending <= w_fire | (r_pending & ~w_clear);
            if ((w_fire & r_pending & ~w_clear) != '0)
                r_overrun <= 1'b1;
            if (w_proto_err)
                r_err <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (r_pending != '0) begin
                        r_state <= ST_WAIT;
                        r_sel   <= w_low_idx;
                        r_lat   <= '0;
                    end
                end
                ST_WAIT: begin
                    if (r_lat != '1)
                        r_lat <= r_lat + 1'b1;
                    if (i_new_irq) begin
                        r_state     <= ST_SERV;
                        r_irq_count <= r_irq_count + 16'd1;
                        if (r_lat > r_max_lat)
                            r_max_lat <= r_lat;
                    end
                end
                ST_SERV: begin
                    if (i_mret)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_ext_irq   = |r_pending;
    assign o_pending   = r_pending;
    assign o_sel       = r_sel;
    assign o_irq_count = r_irq_count;
    assign o_max_lat   = r_max_lat;
    assign o_overrun   = r_overrun;
    assign o_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_servant_irq_stim.sv
`default_nettype none
// ============================================================================
// Module      : tb_servant_irq_stim
// Description : Randomized bench for servant_irq_stim against a schedule-based
//               reference model of timers, arbitration and core protocol.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_servant_irq_stim;

    localparam int CH = 3;
    localparam int CW = 16;
    localparam int TO = 20;

    logic          clk;
    logic          wb_rst_n;
    logic          en, ni, mr;
    logic          ext_irq;
    logic [CH-1:0] pending;
    logic [2:0]    sel;
    logic [15:0]   irq_count;
    logic [CW-1:0] max_lat;
    logic          overrun;
    logic          err;

    servant_irq_stim #(
        .CHANNELS   (CH),
        .CW         (CW),
        .FIRST_TIME ({16'd60, 16'd25, 16'd25}),
        .PERIOD     ({16'd45, 16'd0, 16'd30}),
        .PERIODIC   (3'b101),
        .TIMEOUT    (TO)
    ) u_dut (
        .wb_clk      (clk),
        .wb_rst_n    (wb_rst_n),
        .i_en        (en),
        .i_new_irq   (ni),
        .i_mret      (mr),
        .o_ext_irq   (ext_irq),
        .o_pending   (pending),
        .o_sel       (sel),
        .o_irq_count (irq_count),
        .o_max_lat   (max_lat),
        .o_overrun   (overrun),
        .o_err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Channel schedule: fire on enabled edge F+1, then every P+1 enabled edges if periodic.
    int m_first [CH] = '{25, 25, 60};
    int m_period[CH] = '{30, 0, 45};
    bit m_per   [CH] = '{1'b1, 1'b0, 1'b1};

    int       k;
    bit [2:0] m_pend;
    int       m_st;     // 0 idle, 1 awaiting trap, 2 in handler
    int       m_sel;
    int       m_lat;
    int       m_cnt;
    int       m_max;
    bit       m_ovr;
    bit       m_err;

    function automatic bit fires(int i, int kk);
        if (kk == m_first[i] + 1) return 1'b1;
        if (m_per[i] && kk > m_first[i] + 1 && ((kk - m_first[i] - 1) % (m_period[i] + 1)) == 0)
            return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        k = 0; m_pend = '0; m_st = 0; m_sel = 0; m_lat = 0;
        m_cnt = 0; m_max = 0; m_ovr = 0; m_err = 0;
    endtask

    task automatic model_step(input bit e, input bit n, input bit m);
        bit [2:0] f;
        bit [2:0] clr;
        int       lat_old;
        int       low;
        lat_old = m_lat;
        f = '0;
        clr = '0;
        if (e) k++;
        for (int i = 0; i < CH; i++)
            f[i] = e && fires(i, k);
        if (m_st == 2 && m) clr[m_sel] = 1'b1;
        if ((f & m_pend & ~clr) != 0) m_ovr = 1;
        if (n && m_st != 1) m_err = 1;
        if (m && m_st != 2) m_err = 1;
        if (m_st == 1 && m_lat == TO) m_err = 1;
        low = 0;
        for (int i = CH - 1; i >= 0; i--)
            if (m_pend[i]) low = i;
        case (m_st)
            0: if (m_pend != 0) begin m_st = 1; m_sel = low; m_lat = 0; end
            1: begin
                if (m_lat < 65535) m_lat = m_lat + 1;
                if (n) begin
                    m_st = 2;
                    m_cnt = (m_cnt + 1) % 65536;
                    if (lat_old > m_max) m_max = lat_old;
                end
            end
            default: if (m) m_st = 0;
        endcase
        m_pend = f | (m_pend & ~clr);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ext_irq",   64'(ext_irq),   64'(m_pend != 0));
        chk("pending",   64'(pending),   64'(m_pend));
        chk("sel",       64'(sel),       64'(m_sel));
        chk("irq_count", 64'(irq_count), 64'(m_cnt));
        chk("max_lat",   64'(max_lat),   64'(m_max));
        chk("overrun",   64'(overrun),   64'(m_ovr));
        chk("err",       64'(err),       64'(m_err));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!wb_rst_n) model_reset();
        else model_step(en, ni, mr);
        #1;
        check_all();
    endtask

    // Acts as the core; ph=1 adds slow acks, stray pulses and enable gaps.
    task automatic drive(input int ph);
        ni = 1'b0;
        mr = 1'b0;
        if (m_st == 1 && $urandom_range(0, ph ? 11 : 3) == 0) ni = 1'b1;
        if (m_st == 2 && $urandom_range(0, ph ? 11 : 3) == 0) mr = 1'b1;
        if (ph != 0) begin
            if ($urandom_range(0, 39) == 0) ni = 1'b1;
            if ($urandom_range(0, 39) == 0) mr = 1'b1;
            en = ($urandom_range(0, 9) != 0);
        end else begin
            en = 1'b1;
        end
    endtask

    initial begin
        int guard;
        wb_rst_n = 1'b0;
        en = 1'b0; ni = 1'b0; mr = 1'b0;
        model_reset();
        repeat (3) cycle();
        wb_rst_n = 1'b1;
        en = 1'b1;

        repeat (600) begin drive(0); cycle(); end
        repeat (1500) begin drive(1); cycle(); end

        // Reset while awaiting a trap must clear everything without a clock edge.
        guard = 0;
        while (m_st != 1 && guard < 500) begin drive(0); ni = 1'b0; cycle(); guard++; end
        n_assert++;
        if (m_st != 1) begin
            n_fail++;
            $error("FAIL wait_entry: observed state %0d expected 1 within 500 cycles", m_st);
        end
        #2;
        wb_rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        ni = 1'b0; mr = 1'b0;
        repeat (2) cycle();
        wb_rst_n = 1'b1;

        repeat (400) begin drive(0); cycle(); end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
